traffic_ctrl: RTL and testbench
===============================

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 SHALL have parameter T_MG_MIN, default 20, minimum main-road green duration in cycles.
REQ-002 SHALL have parameter T_Y, default 4, yellow duration in cycles.
REQ-003 SHALL have parameter T_AR, default 2, all-red clearance duration in cycles.
REQ-004 SHALL have parameter T_SG_MIN, default 5, minimum side-road green duration in cycles.
REQ-005 SHALL have parameter T_SG_MAX, default 15, maximum side-road green duration in cycles.
REQ-006 SHALL have parameter CNT_W, default 8, dwell counter width.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 side_req  input  1  side-road vehicle sensor, level-sensitive, already synchronous to clk.
REQ-010 ped_req  input  1  pedestrian button, may be a single-cycle pulse, already synchronous.
REQ-011 main_lt  output  3  main-road lamps {red, yellow, green}, one-hot.
REQ-012 side_lt  output  3  side-road lamps {red, yellow, green}, one-hot.
REQ-013 walk  output  1  pedestrian crossing signal.
REQ-014 state  output  3  current state code, for debug.

Function
REQ-015 SHALL be a Moore machine with states MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5; codes 6-7 SHALL go to MG on the next edge.
REQ-016 All outputs SHALL be decoded from the state register only. No input-to-output combinational path.
REQ-017 Lamps per state: MG main=001 side=100; MY main=010 side=100; AR1/AR2 main=100 side=100; SG main=100 side=001; SY main=100 side=010.
REQ-018 walk SHALL be 1 only in SG.
REQ-019 Dwell counter cnt SHALL be 0 in the first cycle of every state, increment by 1 each cycle, and saturate at 2^CNT_W-1.
REQ-020 MG->MY when cnt >= T_MG_MIN-1 and (side_req or ped_pend), evaluated every cycle.
REQ-021 MY->AR1 when cnt == T_Y-1. AR1->SG when cnt == T_AR-1.
REQ-022 SG->SY when cnt == T_SG_MAX-1, or when cnt >= T_SG_MIN-1 and side_req == 0.
REQ-023 SY->AR2 when cnt == T_Y-1. AR2->MG when cnt == T_AR-1.
REQ-024 Net dwell in timed states: exactly T_Y cycles in MY/SY and T_AR in AR1/AR2. SG dwell SHALL lie in [T_SG_MIN, T_SG_MAX].
REQ-025 ped_pend SHALL be set by ped_req == 1 in any state except SG, and cleared on the edge entering SG.
REQ-026 ped_req == 1 in the same cycle as the AR1->SG edge SHALL leave ped_pend cleared, since it is served by that SG.
REQ-027 ped_req during SG SHALL be ignored.
REQ-028 side_req SHALL NOT be latched; a request that drops before the MG minimum expires is lost.
REQ-029 Parameters SHALL satisfy 1 <= T_SG_MIN <= T_SG_MAX, all T_* >= 1, all T_* <= 2^CNT_W-1; other values are unsupported.

Reset
REQ-030 reset == 1 at a rising edge SHALL force state=MG, cnt=0, ped_pend=0, regardless of current state, including mid-SG or mid-yellow.
REQ-031 During and after reset, outputs SHALL be main=001, side=100, walk=0, state=0.
REQ-032 The first post-reset MG dwell SHALL again require the full T_MG_MIN.

Verification (default parameters, cycle 0 = first cycle after reset release)
REQ-033 No requests for 200 cycles -> state stays MG, main=001, side=100, walk=0.
REQ-034 side_req held 1 from cycle 0 -> MG cycles 0-19, MY 20-23, AR1 24-25, SG 26-40 (max, 15 cycles), SY 41-44, AR2 45-46, MG from 47, then MY again at 67.
REQ-035 ped_req pulse at cycle 3, side_req 0 -> MY at 20, SG 26-30 with walk=1 (5 cycles), SY at 31, MG at 37, then MG indefinitely (ped_pend cleared).
REQ-036 side_req high cycles 5-7 only -> no transition; MG for 200 cycles.
REQ-037 side_req 1 until cycle 33, then 0 -> SG 26-33 (8 cycles), SY at 34.
REQ-038 reset pulsed at cycle 28 (in SG) with ped_req pulsed at 27 -> state=MG and walk=0 from cycle 29; no SG until T_MG_MIN elapses with a new request.

Source files
------------

// File: rtl/traffic_ctrl.sv
// Two-road intersection controller with pedestrian walk phase.
// Moore FSM; every output is decoded from the state register.
module traffic_ctrl #(
    parameter int T_MG_MIN = 20,
    parameter int T_Y      = 4,
    parameter int T_AR     = 2,
    parameter int T_SG_MIN = 5,
    parameter int T_SG_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_lt,
    output logic [2:0] side_lt,
    output logic       walk,
    output logic [2:0] state
);

    localparam logic [2:0] S_MG  = 3'd0;
    localparam logic [2:0] S_MY  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_SG  = 3'd3;
    localparam logic [2:0] S_SY  = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;

    localparam logic [CNT_W-1:0] C_MG  = CNT_W'(T_MG_MIN - 1);
    localparam logic [CNT_W-1:0] C_Y   = CNT_W'(T_Y - 1);
    localparam logic [CNT_W-1:0] C_AR  = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] C_SGN = CNT_W'(T_SG_MIN - 1);
    localparam logic [CNT_W-1:0] C_SGX = CNT_W'(T_SG_MAX - 1);
    localparam logic [CNT_W-1:0] C_SAT = '1;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ped_pend;
    logic [2:0]       w_next;
    logic             w_enter_sg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_MG;
        end else begin
            r_state <= w_next;
        end
    end

    // Dwell counter restarts on every state change, saturates otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != C_SAT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_enter_sg = (r_state == S_AR1) && (w_next == S_SG);

    // Entering SG serves the pending walk, even if the button is pressed on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ped_pend <= 1'b0;
        end else if (w_enter_sg) begin
            r_ped_pend <= 1'b0;
        end else if (ped_req && (r_state != S_SG)) begin
            r_ped_pend <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_MG: begin
                if ((r_cnt >= C_MG) && (side_req || r_ped_pend))
                    w_next = S_MY;
            end
            S_MY: begin
                if (r_cnt == C_Y)
                    w_next = S_AR1;
            end
            S_AR1: begin
                if (r_cnt == C_AR)
                    w_next = S_SG;
            end
            S_SG: begin
                if ((r_cnt == C_SGX) || ((r_cnt >= C_SGN) && !side_req))
                    w_next = S_SY;
            end
            S_SY: begin
                if (r_cnt == C_Y)
                    w_next = S_AR2;
            end
            S_AR2: begin
                if (r_cnt == C_AR)
                    w_next = S_MG;
            end
            default: w_next = S_MG;
        endcase
    end

    always_comb begin
        main_lt = 3'b001;
        side_lt = 3'b100;
        walk    = 1'b0;
        case (r_state)
            S_MY: begin
                main_lt = 3'b010;
            end
            S_AR1, S_AR2: begin
                main_lt = 3'b100;
            end
            S_SG: begin
                main_lt = 3'b100;
                side_lt = 3'b001;
                walk    = 1'b1;
            end
            S_SY: begin
                main_lt = 3'b100;
                side_lt = 3'b010;
            end
            default: begin
                main_lt = 3'b001;
                side_lt = 3'b100;
                walk    = 1'b0;
            end
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed-sequence bench for traffic_ctrl at default parameters.
// Cycle 0 is the first cycle after reset release.
module tb_traffic_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       side_req;
    logic       ped_req;
    logic [2:0] main_lt;
    logic [2:0] side_lt;
    logic       walk;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    localparam logic [2:0] MG  = 3'd0;
    localparam logic [2:0] MY  = 3'd1;
    localparam logic [2:0] AR1 = 3'd2;
    localparam logic [2:0] SG  = 3'd3;
    localparam logic [2:0] SY  = 3'd4;
    localparam logic [2:0] AR2 = 3'd5;

    traffic_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .side_req (side_req),
        .ped_req  (ped_req),
        .main_lt  (main_lt),
        .side_lt  (side_lt),
        .walk     (walk),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Expected phase given the cycle MY starts and the SG length (T_Y=4, T_AR=2).
    function automatic logic [2:0] phase(input int c, input int my, input int sgl);
        if (c < my)                 return MG;
        else if (c < my + 4)        return MY;
        else if (c < my + 6)        return AR1;
        else if (c < my + 6 + sgl)  return SG;
        else if (c < my + 10 + sgl) return SY;
        else if (c < my + 12 + sgl) return AR2;
        else                        return MG;
    endfunction

    function automatic logic [2:0] exp_main(input logic [2:0] s);
        case (s)
            MG:      return 3'b001;
            MY:      return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] s);
        case (s)
            SG:      return 3'b001;
            SY:      return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic chk(input string tag, input int c, input logic [2:0] es);
        logic [2:0] em;
        logic [2:0] eside;
        logic       ew;
        em    = exp_main(es);
        eside = exp_side(es);
        ew    = (es == SG);
        total++;
        assert (state === es) else begin
            bad++;
            $error("FAIL %s c=%0d state got=%0d exp=%0d", tag, c, state, es);
        end
        total++;
        assert (main_lt === em) else begin
            bad++;
            $error("FAIL %s c=%0d main got=%b exp=%b", tag, c, main_lt, em);
        end
        total++;
        assert (side_lt === eside) else begin
            bad++;
            $error("FAIL %s c=%0d side got=%b exp=%b", tag, c, side_lt, eside);
        end
        total++;
        assert (walk === ew) else begin
            bad++;
            $error("FAIL %s c=%0d walk got=%b exp=%b", tag, c, walk, ew);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        side_req = 1'b0;
        ped_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset", -1, MG);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        // Idle: no requests for 200 cycles
        do_reset();
        for (int c = 0; c < 200; c++) begin
            chk("idle", c, MG);
            tick();
        end

        // side_req held: max SG then a second cycle at 67
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            side_req = 1'b1;
            chk("side_hold", c, (c >= 67) ? MY : phase(c, 20, 15));
            tick();
        end

        // Single ped pulse: min SG then MG forever
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            ped_req = (c == 3);
            chk("ped", c, phase(c, 20, 5));
            tick();
        end

        // Ped on AR1->SG edge and during SG must not re-trigger
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            ped_req = (c == 3) || (c == 25) || (c == 28);
            chk("ped_edge", c, phase(c, 20, 5));
            tick();
        end

        // Short side request before MG minimum is lost
        do_reset();
        for (int c = 0; c < 200; c++) begin
            side_req = (c >= 5) && (c <= 7);
            ped_req  = 1'b0;
            chk("side_short", c, MG);
            tick();
        end

        // side_req drops at 33: SG 26-33, SY at 34
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            side_req = (c <= 32);
            chk("side_drop", c, phase(c, 20, 8));
            tick();
        end

        // Reset mid-SG: back to MG at 29, full minimum before next MY at 49
        do_reset();
        for (int c = 0; c <= 55; c++) begin
            side_req = 1'b1;
            ped_req  = (c == 27);
            reset    = (c == 28);
            chk("reset_sg", c, (c <= 28) ? phase(c, 20, 15) : phase(c - 29, 20, 15));
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
